// File: rtl/nist_test_sequencer.sv
// -----------------------------------------------------------------------------
// nist_test_sequencer
//
// Purpose:
//   Drives an external NIST randomness test bank through a campaign of N_RUNS
//   runs. Each run holds the bank in reset for CLR_CYCLES cycles, streams
//   WINDOW_LEN raw random bits into it, then spends one evaluation cycle
//   collecting its error outputs. Failing runs are counted, and per-test
//   failure flags stay sticky for the whole campaign. The campaign passes if
//   no more than MAX_FAIL runs failed.
//
//   One campaign takes N_RUNS*(CLR_CYCLES+WINDOW_LEN+1) cycles, measured from
//   the edge that samples start to the first cycle with done=1.
//
// Parameters:
//   WINDOW_LEN  random bits streamed per run (2..65535)
//   N_RUNS      runs per campaign (1..15)
//   CLR_CYCLES  cycles the test bank is held in reset before each run (1..15)
//   MAX_FAIL    largest failing-run count that still passes (0..15)
//
// Ports:
//   clk         single clock; all state changes on its rising edge
//   rstn        asynchronous active-low reset
//   start       campaign start request (acted on only in IDLE or DONE)
//   abort       campaign abort request (acted on only while busy)
//   RND_in      raw random bit stream under test
//   err_in      error1..error4 from the test bank (bit 0 = error1)
//   test_rstn   active-low reset to the test bank
//   RND_out     gated bit stream to the test bank
//   busy        a campaign is in progress (CLEAR, RUN or EVAL)
//   done        a campaign has completed (DONE)
//   pass        completed campaign met the MAX_FAIL limit
//   fail_flags  sticky per-test failure flags for the current campaign
//   fail_runs   number of failing runs, saturating at 15
//   run_idx     index of the current run
// -----------------------------------------------------------------------------
module nist_test_sequencer #(
  parameter int WINDOW_LEN = 1024,
  parameter int N_RUNS     = 8,
  parameter int CLR_CYCLES = 2,
  parameter int MAX_FAIL   = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       abort,
  input  logic       RND_in,
  input  logic [3:0] err_in,
  output logic       test_rstn,
  output logic       RND_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_flags,
  output logic [3:0] fail_runs,
  output logic [3:0] run_idx
);

  // Width of the bit counter, sized to hold WINDOW_LEN-1.
  localparam int CNT_W = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    EVAL,
    DONE
  } state_t;

  state_t     state;
  state_t     next_state;

  logic [3:0]       clr_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       run_err;

  logic in_campaign;
  logic collecting;
  logic start_campaign;
  logic clr_last;
  logic bit_last;
  logic last_run;
  logic run_failed;

  // Decoded conditions shared by the FSM and the datapath. A start request
  // is only honoured from IDLE or DONE; abort only matters while busy, so a
  // simultaneous start/abort resolves to whichever one the state accepts.
  always_comb begin
    in_campaign    = (state == CLEAR) || (state == RUN) || (state == EVAL);
    collecting     = (state == RUN) || (state == EVAL);
    start_campaign = ((state == IDLE) || (state == DONE)) && start;
    clr_last       = (clr_cnt == 4'(CLR_CYCLES - 1));
    bit_last       = (bit_cnt == CNT_W'(WINDOW_LEN - 1));
    last_run       = (run_idx == 4'(N_RUNS - 1));
    run_failed     = ((run_err | err_in) != 4'b0000);
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Abort takes priority over the normal phase progression
  // in every busy state.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = CLEAR;
        end
      end
      CLEAR: begin
        if (abort) begin
          next_state = IDLE;
        end else if (clr_last) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          next_state = IDLE;
        end else if (bit_last) begin
          next_state = EVAL;
        end
      end
      EVAL: begin
        if (abort) begin
          next_state = IDLE;
        end else if (last_run) begin
          next_state = DONE;
        end else begin
          next_state = CLEAR;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode. The test bank is released from reset through RUN and EVAL,
  // but only sees random bits during RUN; RND_out is a combinational gate of
  // RND_in so the bank receives the stream without an extra cycle of delay.
  always_comb begin
    test_rstn = 1'b0;
    RND_out   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
      end
      RUN: begin
        test_rstn = 1'b1;
        RND_out   = RND_in;
        busy      = 1'b1;
      end
      EVAL: begin
        test_rstn = 1'b1;
        busy      = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        pass = (fail_runs <= 4'(MAX_FAIL));
      end
      default: begin
        test_rstn = 1'b0;
      end
    endcase
  end

  // Reset-hold counter. It only advances while in CLEAR and rests at zero
  // everywhere else, so every entry into CLEAR starts a fresh count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clr_cnt <= '0;
    end else if ((state == CLEAR) && !abort && !clr_last) begin
      clr_cnt <= clr_cnt + 4'd1;
    end else begin
      clr_cnt <= '0;
    end
  end

  // Bit counter for the streaming window, 0..WINDOW_LEN-1, same scheme as
  // the reset-hold counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt <= '0;
    end else if ((state == RUN) && !abort && !bit_last) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end else begin
      bit_cnt <= '0;
    end
  end

  // Run index. Advances on the way out of EVAL unless this was the last run,
  // in which case it stays put so DONE reports the final run. An abort leaves
  // it where it was.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_idx <= '0;
    end else if (start_campaign) begin
      run_idx <= '0;
    end else if ((state == EVAL) && !abort && !last_run) begin
      run_idx <= run_idx + 4'd1;
    end
  end

  // Sticky campaign-wide failure flags. Errors are only meaningful while the
  // bank is out of reset, i.e. RUN and EVAL.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fail_flags <= '0;
    end else if (start_campaign) begin
      fail_flags <= '0;
    end else if (collecting) begin
      fail_flags <= fail_flags | err_in;
    end
  end

  // Per-run error accumulator. It is emptied on every exit from EVAL and on
  // abort so that the next run starts clean.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_err <= '0;
    end else if (start_campaign) begin
      run_err <= '0;
    end else if ((state == EVAL) || (in_campaign && abort)) begin
      run_err <= '0;
    end else if (state == RUN) begin
      run_err <= run_err | err_in;
    end
  end

  // Failing-run counter. The EVAL-cycle errors are folded in directly since
  // they never reach run_err. An aborted EVAL does not count its run.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fail_runs <= '0;
    end else if (start_campaign) begin
      fail_runs <= '0;
    end else if ((state == EVAL) && !abort && run_failed &&
                 (fail_runs != 4'd15)) begin
      fail_runs <= fail_runs + 4'd1;
    end
  end

endmodule

// File: tb/tb_nist_test_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nist_test_sequencer
//
// Self-checking bench for nist_test_sequencer with a short window so complete
// campaigns are cheap. A table of campaign vectors describes where errors are
// injected and what the final flags/counts/pass must be; each campaign's
// expected result is queued when it is started and popped when done appears.
// Hand-written sequences cover reset, abort and asynchronous reset mid-run.
// -----------------------------------------------------------------------------
module tb_nist_test_sequencer;

  localparam int WL       = 8;
  localparam int NR       = 3;
  localparam int CC       = 2;
  localparam int MF       = 1;
  localparam int RUN_LEN  = CC + WL + 1;
  localparam int CAMP_LEN = NR * RUN_LEN;

  localparam int PH_CLR  = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_EVAL = 2;
  localparam int N_VECS  = 6;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       abort;
  logic       rnd_in;
  logic [3:0] err_in;
  logic       test_rstn;
  logic       rnd_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_flags;
  logic [3:0] fail_runs;
  logic [3:0] run_idx;

  nist_test_sequencer #(
    .WINDOW_LEN(WL),
    .N_RUNS    (NR),
    .CLR_CYCLES(CC),
    .MAX_FAIL  (MF)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .RND_in    (rnd_in),
    .err_in    (err_in),
    .test_rstn (test_rstn),
    .RND_out   (rnd_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_flags(fail_flags),
    .fail_runs (fail_runs),
    .run_idx   (run_idx)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // One campaign description: an optional error held on every cycle, two
  // single-cycle injections located by (run, phase, offset), and the final
  // result the campaign must report.
  typedef struct {
    string      name;
    logic       hold;
    logic [3:0] hold_val;
    logic [3:0] a_val;
    int         a_run;
    int         a_ph;
    int         a_off;
    logic [3:0] b_val;
    int         b_run;
    int         b_ph;
    int         b_off;
    logic [3:0] exp_flags;
    logic [3:0] exp_runs;
    logic       exp_pass;
  } vec_t;

  vec_t vecs[N_VECS];
  vec_t sb_q[$];
  int   vec_count   = 0;
  int   miscompares = 0;

  // Build one vector record.
  function automatic vec_t mkVec(input string name, input logic hold,
                                 input logic [3:0] hold_val,
                                 input logic [3:0] a_val, input int a_run,
                                 input int a_ph, input int a_off,
                                 input logic [3:0] b_val, input int b_run,
                                 input int b_ph, input int b_off,
                                 input logic [3:0] exp_flags,
                                 input logic [3:0] exp_runs,
                                 input logic exp_pass);
    vec_t v;
    v.name      = name;
    v.hold      = hold;
    v.hold_val  = hold_val;
    v.a_val     = a_val;
    v.a_run     = a_run;
    v.a_ph      = a_ph;
    v.a_off     = a_off;
    v.b_val     = b_val;
    v.b_run     = b_run;
    v.b_ph      = b_ph;
    v.b_off     = b_off;
    v.exp_flags = exp_flags;
    v.exp_runs  = exp_runs;
    v.exp_pass  = exp_pass;
    return v;
  endfunction

  // err_in value for cycle k after the start edge, derived purely from the
  // campaign timing arithmetic (k -> run, phase, offset).
  function automatic logic [3:0] errFor(input vec_t v, input int k);
    int         run;
    int         p;
    int         ph;
    int         off;
    logic [3:0] e;
    run = k / RUN_LEN;
    p   = k % RUN_LEN;
    if (p < CC) begin
      ph  = PH_CLR;
      off = p;
    end else if (p < CC + WL) begin
      ph  = PH_RUN;
      off = p - CC;
    end else begin
      ph  = PH_EVAL;
      off = 0;
    end
    e = v.hold ? v.hold_val : 4'b0000;
    if (v.a_run == run && v.a_ph == ph && v.a_off == off) e = e | v.a_val;
    if (v.b_run == run && v.b_ph == ph && v.b_off == off) e = e | v.b_val;
    return e;
  endfunction

  // Drive all DUT control/data inputs at once.
  task automatic applyStimulus(input logic s, input logic a,
                               input logic [3:0] e, input logic r);
    start  = s;
    abort  = a;
    err_in = e;
    rnd_in = r;
  endtask

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  // Run one full campaign from IDLE/DONE, checking the per-cycle waveform
  // and, when done appears, the queued final result.
  task automatic runCampaign(input vec_t v);
    logic       r;
    logic [3:0] e;
    int         p;
    vec_t       got;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, v.hold ? v.hold_val : 4'b0000, 1'b0);
    sb_q.push_back(v);
    @(posedge clk);
    for (int k = 0; k < CAMP_LEN; k++) begin
      @(negedge clk);
      r = 1'($urandom_range(0, 1));
      e = errFor(v, k);
      // A start pulse in the middle of the campaign must be ignored.
      applyStimulus(k == 12, 1'b0, e, r);
      #1;
      p = k % RUN_LEN;
      if (k == 0) begin
        checkOutput({v.name, " cleared fail_flags"}, 32'(fail_flags), 32'd0);
        checkOutput({v.name, " cleared fail_runs"}, 32'(fail_runs), 32'd0);
        checkOutput({v.name, " pass low when busy"}, 32'(pass), 32'd0);
        checkOutput({v.name, " done low when busy"}, 32'(done), 32'd0);
      end
      checkOutput({v.name, " test_rstn"}, 32'(test_rstn), 32'(p >= CC));
      checkOutput({v.name, " busy"}, 32'(busy), 32'd1);
      checkOutput({v.name, " run_idx"}, 32'(run_idx), 32'(k / RUN_LEN));
      checkOutput({v.name, " RND_out"}, 32'(rnd_out),
                  ((p >= CC) && (p < CC + WL)) ? 32'(r) : 32'd0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
    #1;
    checkOutput({v.name, " done latency"}, 32'(done), 32'd1);
    got = sb_q.pop_front();
    checkOutput({got.name, " fail_flags"}, 32'(fail_flags), 32'(got.exp_flags));
    checkOutput({got.name, " fail_runs"}, 32'(fail_runs), 32'(got.exp_runs));
    checkOutput({got.name, " pass"}, 32'(pass), 32'(got.exp_pass));
    checkOutput({got.name, " busy in DONE"}, 32'(busy), 32'd0);
    checkOutput({got.name, " test_rstn in DONE"}, 32'(test_rstn), 32'd0);
    checkOutput({got.name, " RND_out in DONE"}, 32'(rnd_out), 32'd0);
    checkOutput({got.name, " run_idx in DONE"}, 32'(run_idx), 32'(NR - 1));
  endtask

  // Abort with simultaneous start during run 1, restart, then an
  // asynchronous reset in the middle of a RUN phase.
  task automatic abortAndResetSequence();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
    @(posedge clk);
    // k=3 is run 0 RUN offset 1; k=16 is run 1 RUN offset 3.
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      applyStimulus(k == 16, k == 16, (k == 3) ? 4'b0100 : 4'b0000, 1'b0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort pass", 32'(pass), 32'd0);
    checkOutput("abort test_rstn", 32'(test_rstn), 32'd0);
    checkOutput("abort RND_out", 32'(rnd_out), 32'd0);
    checkOutput("abort run_idx kept", 32'(run_idx), 32'd1);
    checkOutput("abort fail_flags kept", 32'(fail_flags), 32'h4);
    checkOutput("abort fail_runs kept", 32'(fail_runs), 32'd1);

    // Restart from IDLE: everything cleared.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
    #1;
    checkOutput("restart busy", 32'(busy), 32'd1);
    checkOutput("restart run_idx", 32'(run_idx), 32'd0);
    checkOutput("restart fail_flags", 32'(fail_flags), 32'd0);
    checkOutput("restart fail_runs", 32'(fail_runs), 32'd0);
    checkOutput("restart test_rstn", 32'(test_rstn), 32'd0);

    // Advance to k=5 (RUN offset 3) with an error at k=3.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, (k == 3) ? 4'b0010 : 4'b0000, 1'b1);
    end
    #1;
    checkOutput("pre-reset test_rstn", 32'(test_rstn), 32'd1);
    checkOutput("pre-reset RND_out", 32'(rnd_out), 32'd1);
    checkOutput("pre-reset fail_flags", 32'(fail_flags), 32'h2);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async reset test_rstn", 32'(test_rstn), 32'd0);
    checkOutput("async reset RND_out", 32'(rnd_out), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset done", 32'(done), 32'd0);
    checkOutput("async reset pass", 32'(pass), 32'd0);
    checkOutput("async reset fail_flags", 32'(fail_flags), 32'd0);
    checkOutput("async reset fail_runs", 32'(fail_runs), 32'd0);
    checkOutput("async reset run_idx", 32'(run_idx), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("no resume after reset", 32'(busy), 32'd0);
  endtask

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec_count,
             miscompares + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    rstn = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
    #1;
    checkOutput("reset test_rstn", 32'(test_rstn), 32'd0);
    checkOutput("reset RND_out", 32'(rnd_out), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset pass", 32'(pass), 32'd0);
    checkOutput("reset fail_flags", 32'(fail_flags), 32'd0);
    checkOutput("reset fail_runs", 32'(fail_runs), 32'd0);
    checkOutput("reset run_idx", 32'(run_idx), 32'd0);
    #20;
    @(negedge clk);
    rstn = 1'b1;

    vecs[0] = mkVec("clean", 1'b0, 4'h0,
                    4'h0, -1, 0, 0, 4'h0, -1, 0, 0,
                    4'b0000, 4'd0, 1'b1);
    vecs[1] = mkVec("run0/eval2 errors", 1'b0, 4'h0,
                    4'b0010, 0, PH_RUN, 3, 4'b1000, 2, PH_EVAL, 0,
                    4'b1010, 4'd2, 1'b0);
    vecs[2] = mkVec("held error1", 1'b1, 4'b0001,
                    4'h0, -1, 0, 0, 4'h0, -1, 0, 0,
                    4'b0001, 4'd3, 1'b0);
    vecs[3] = mkVec("clear-only errors", 1'b0, 4'h0,
                    4'b1111, 1, PH_CLR, 0, 4'b0100, 2, PH_CLR, 1,
                    4'b0000, 4'd0, 1'b1);
    vecs[4] = mkVec("last bit error", 1'b0, 4'h0,
                    4'b0100, 1, PH_RUN, WL - 1, 4'h0, -1, 0, 0,
                    4'b0100, 4'd1, 1'b1);
    vecs[5] = mkVec("eval0 and first bit", 1'b0, 4'h0,
                    4'b0001, 0, PH_EVAL, 0, 4'b0010, 1, PH_RUN, 0,
                    4'b0011, 4'd2, 1'b0);

    for (int i = 0; i < N_VECS; i++) begin
      runCampaign(vecs[i]);
    end

    abortAndResetSequence();

    checkOutput("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count,
             miscompares);
    $finish;
  end

endmodule

// File: doc/nist_test_sequencer.md
NIST_TEST_SEQUENCER -- requirements
Module: nist_test_sequencer

Interface
REQ-001 SHALL have parameter WINDOW_LEN, default 1024: RND bits streamed per run, range 2..65535.
REQ-002 SHALL have parameter N_RUNS, default 8: runs per campaign, range 1..15.
REQ-003 SHALL have parameter CLR_CYCLES, default 2: cycles the test bank is held in reset before each run, range 1..15.
REQ-004 SHALL have parameter MAX_FAIL, default 1: maximum failing runs for campaign pass, range 0..15.
REQ-005 SHALL have port clk  input  1  single clock, all state on its rising edge.
REQ-006 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  campaign start request, sampled per cycle.
REQ-008 SHALL have port abort  input  1  campaign abort request.
REQ-009 SHALL have port RND_in  input  1  raw random bit stream under test.
REQ-010 SHALL have port err_in  input  4  error1..error4 of the NIST test bank, bit 0 = error1.
REQ-011 SHALL have port test_rstn  output  1  active-low reset driven to the test bank.
REQ-012 SHALL have port RND_out  output  1  gated bit stream driven to the test bank RND_in.
REQ-013 SHALL have port busy, done, pass  output  1 each  campaign status.
REQ-014 SHALL have port fail_flags  output  4  sticky per-test failure flags for current campaign.
REQ-015 SHALL have port fail_runs  output  4  count of failing runs; run_idx  output  4  index of current run.

Function
REQ-016 SHALL implement states IDLE, CLEAR, RUN, EVAL, DONE; encoding free.
REQ-017 IDLE: test_rstn=0, RND_out=0, busy=0, done=0; start=1 -> CLEAR, clearing fail_flags, fail_runs, run_idx and per-run error register run_err.
REQ-018 CLEAR: test_rstn=0, RND_out=0, busy=1; exactly CLR_CYCLES cycles, then RUN.
REQ-019 RUN: test_rstn=1, RND_out=RND_in combinationally, busy=1; exactly WINDOW_LEN cycles counted by bit counter 0..WINDOW_LEN-1, then EVAL.
REQ-020 EVAL: exactly 1 cycle, test_rstn=1, RND_out=0, busy=1.
REQ-021 In RUN and EVAL each cycle: run_err |= err_in and fail_flags |= err_in; err_in ignored in IDLE, CLEAR, DONE.
REQ-022 Leaving EVAL: fail_runs += 1 if (run_err | err_in) != 0, saturating at 15; run_err cleared; if run_idx == N_RUNS-1 -> DONE, else run_idx += 1 and -> CLEAR.
REQ-023 DONE: done=1, busy=0, test_rstn=0, RND_out=0; fail_flags, fail_runs, run_idx held; start=1 -> CLEAR with same clearing as REQ-017.
REQ-024 pass SHALL be 1 only in DONE and only when fail_runs <= MAX_FAIL; 0 otherwise.
REQ-025 start while busy SHALL be ignored.
REQ-026 abort=1 in CLEAR, RUN or EVAL SHALL go to IDLE next cycle; fail_flags, fail_runs, run_idx retained; pending EVAL count not applied.
REQ-027 abort and start asserted together: abort wins when busy; in IDLE/DONE abort is ignored and start acts.
REQ-028 Campaign length from the edge sampling start to done=1 SHALL be N_RUNS*(CLR_CYCLES+WINDOW_LEN+1) cycles.

Reset
REQ-029 rstn=0 SHALL asynchronously force IDLE; test_rstn=0, RND_out=0, busy=0, done=0, pass=0, fail_flags=0, fail_runs=0, run_idx=0, all counters 0.
REQ-030 Reset mid-campaign SHALL discard all results; operation resumes only on a new start after rstn=1.

Verification (WINDOW_LEN=8, N_RUNS=3, CLR_CYCLES=2, MAX_FAIL=1)
REQ-031 err_in=0, start pulse -> test_rstn low 2 cycles, high 9 cycles, per run x3; done=1, pass=1, fail_runs=0 exactly 33 cycles after start edge.
REQ-032 err_in=4'b0010 for one cycle in run 0 RUN, one cycle of 4'b1000 in run 2 EVAL -> fail_flags=4'b1010, fail_runs=2, pass=0.
REQ-033 err_in=4'b0001 held through all cycles -> fail_flags=4'b0001, fail_runs=3, pass=0; err during CLEAR alone -> no effect.
REQ-034 abort in run 1 RUN, simultaneous start -> IDLE next cycle, busy=0, done=0, run_idx=1 retained; later start clears and restarts.
REQ-035 rstn low mid-RUN -> all outputs reset immediately without clock edge; start in DONE -> new campaign, pass=0, fail_runs cleared.
